// File: rtl/cpu_clock_sequencer_if.sv
// Control/status bundle between the board logic and cpu_clock_sequencer.
// Optional CYCLE_COUNT_EN adds the cpu_cycles counter output.
interface cpu_clock_sequencer_if #(
    parameter int CNT_W = 27
);
    // No valid/ready handshake: every input is a level sampled on each clk_50
    // edge, and every output is a level that is valid on every cycle.
    logic [1:0]       mode;
    logic             push_manual_clock;
    logic             FLAG_input;
    logic             FPGA_input_confirm;
    logic             halt;
    logic             clock;
    logic             clock_status;
    logic             stalled;
    logic             busy;
    logic [CNT_W-1:0] burst_left;
    logic [1:0]       dbg_state;
`ifdef CYCLE_COUNT_EN
    logic [31:0]      cpu_cycles;

    modport master (
        output mode, push_manual_clock, FLAG_input, FPGA_input_confirm, halt,
        input  clock, clock_status, stalled, busy, burst_left, dbg_state, cpu_cycles
    );
    modport slave (
        input  mode, push_manual_clock, FLAG_input, FPGA_input_confirm, halt,
        output clock, clock_status, stalled, busy, burst_left, dbg_state, cpu_cycles
    );
`else
    modport master (
        output mode, push_manual_clock, FLAG_input, FPGA_input_confirm, halt,
        input  clock, clock_status, stalled, busy, burst_left, dbg_state
    );
    modport slave (
        input  mode, push_manual_clock, FLAG_input, FPGA_input_confirm, halt,
        output clock, clock_status, stalled, busy, burst_left, dbg_state
    );
`endif
endinterface

// File: rtl/cpu_clock_sequencer.sv
// CPU clock generator: run / single-step / burst / hold with debounced button and stall.
// Optional CYCLE_COUNT_EN adds a 32-bit count of CPU clock rising edges.
module cpu_clock_sequencer #(
    parameter int DIV_HALF        = 3000000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BURST_LEN       = 16,
    parameter int CNT_W           = 27
) (
    input  logic              clk_50,
    input  logic              reset,
    cpu_clock_sequencer_if.slave bus
);
    // Bit 0 is set only in HIGH so the CPU clock comes straight off a flop.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_HIGH = 2'b01;
    localparam logic [1:0] S_LOW  = 2'b10;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_HALF - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BURST_INIT = CNT_W'(BURST_LEN);

    logic             r_sync1;
    logic             r_sync_b;
    logic             r_stable;
    logic             r_prev_stable;
    logic [CNT_W-1:0] r_db_cnt;
    logic             w_press;
    logic             w_stall;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_div;
    logic             w_div_last;
    logic [CNT_W-1:0] r_burst_left;
    logic [CNT_W-1:0] w_burst_next;
    logic [CNT_W-1:0] w_burst_dec;
    logic             r_stalled;
    logic             r_clock_status;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_sync1       <= 1'b1;
            r_sync_b      <= 1'b1;
            r_stable      <= 1'b1;
            r_prev_stable <= 1'b1;
            r_db_cnt      <= '0;
        end else begin
            r_sync1       <= bus.push_manual_clock;
            r_sync_b      <= r_sync1;
            r_prev_stable <= r_stable;
            if (r_sync_b != r_stable) begin
                if (r_db_cnt == DEB_LAST) begin
                    r_stable <= r_sync_b;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + CNT_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press    = r_prev_stable & ~r_stable;
    assign w_stall    = bus.halt | (bus.FLAG_input & ~bus.FPGA_input_confirm);
    assign w_div_last = (r_div == DIV_LAST);

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state || r_state == S_IDLE) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + CNT_W'(1);
            end
        end
    end

    // Mode and stall are only looked at when leaving IDLE or finishing LOW,
    // so a started period always runs to completion.
    always_comb begin
        w_next_state = r_state;
        w_burst_next = r_burst_left;
        w_burst_dec  = (r_burst_left != '0) ? r_burst_left - CNT_W'(1) : '0;
        case (r_state)
            S_IDLE: begin
                if (!w_stall) begin
                    if (bus.mode == 2'b00 || (bus.mode == 2'b01 && w_press)) begin
                        w_next_state = S_HIGH;
                    end else if (bus.mode == 2'b10 && w_press) begin
                        w_next_state = S_HIGH;
                        w_burst_next = BURST_INIT;
                    end
                end
            end
            S_HIGH: begin
                if (w_div_last) w_next_state = S_LOW;
            end
            S_LOW: begin
                if (w_div_last) begin
                    w_burst_next = (bus.mode == 2'b10) ? w_burst_dec : '0;
                    if (!w_stall && (bus.mode == 2'b00 ||
                                     (bus.mode == 2'b10 && w_burst_dec != '0))) begin
                        w_next_state = S_HIGH;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_burst_left   <= '0;
            r_stalled      <= 1'b0;
            r_clock_status <= 1'b0;
        end else begin
            r_burst_left   <= w_burst_next;
            r_stalled      <= w_stall;
            r_clock_status <= w_stall ? 1'b1 : r_state[0];
        end
    end

    always_comb begin
        bus.clock = r_state[0];
        bus.busy  = (r_state != S_IDLE) | (r_burst_left != '0);
    end

    assign bus.clock_status = r_clock_status;
    assign bus.stalled      = r_stalled;
    assign bus.burst_left   = r_burst_left;
    assign bus.dbg_state    = r_state;

`ifdef CYCLE_COUNT_EN
    logic [31:0] r_cpu_cycles;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_cpu_cycles <= '0;
        end else if (w_next_state == S_HIGH && r_state != S_HIGH) begin
            r_cpu_cycles <= r_cpu_cycles + 32'd1;
        end
    end

    assign bus.cpu_cycles = r_cpu_cycles;
`endif
endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Directed + random bench for cpu_clock_sequencer against a period-position model.
module tb_cpu_clock_sequencer;
    localparam int DH  = 4;
    localparam int DEB = 8;
    localparam int BL  = 3;
    localparam int CW  = 8;

    logic clk_50 = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #10 clk_50 = ~clk_50;

    cpu_clock_sequencer_if #(.CNT_W(CW)) bus();

    cpu_clock_sequencer #(
        .DIV_HALF(DH), .DEBOUNCE_CYCLES(DEB), .BURST_LEN(BL), .CNT_W(CW)
    ) dut (
        .clk_50(clk_50),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference: a period is a position 0..2*DH-1; clock is high in the first half.
    logic            sync_q[$];
    logic            m_stable;
    logic            m_prev;
    int              m_run;
    bit              m_active;
    int              m_pos;
    int              m_bursts;
    logic            m_cs;
    logic            m_stalled;
    logic [CW+3:0]   exp_q[$];
    int              rises;
    logic            last_clock;

    function automatic logic m_clock();
        return (m_active && m_pos < DH) ? 1'b1 : 1'b0;
    endfunction

    task automatic model_reset();
        sync_q    = {1'b1, 1'b1};
        m_stable  = 1'b1;
        m_prev    = 1'b1;
        m_run     = 0;
        m_active  = 1'b0;
        m_pos     = 0;
        m_bursts  = 0;
        m_cs      = 1'b0;
        m_stalled = 1'b0;
    endtask

    task automatic model_edge();
        logic sb, press, stall, clk_old;
        logic [CW-1:0] bl;
        int b;
        if (reset) begin
            model_reset();
        end else begin
            stall   = bus.halt | (bus.FLAG_input & ~bus.FPGA_input_confirm);
            press   = m_prev & ~m_stable;
            clk_old = m_clock();
            if (!m_active) begin
                if (!stall && (bus.mode == 2'd0 || ((bus.mode == 2'd1 || bus.mode == 2'd2) && press))) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                    if (bus.mode == 2'd2) m_bursts = BL;
                end
            end else if (m_pos < 2*DH-1) begin
                m_pos++;
            end else begin
                b = (m_bursts > 0) ? m_bursts - 1 : 0;
                if (bus.mode != 2'd2) b = 0;
                m_bursts = b;
                m_pos    = 0;
                if (!(!stall && (bus.mode == 2'd0 || (bus.mode == 2'd2 && b != 0)))) m_active = 1'b0;
            end
            m_cs      = stall ? 1'b1 : clk_old;
            m_stalled = stall;
            sb = sync_q.pop_front();
            sync_q.push_back(bus.push_manual_clock);
            m_prev = m_stable;
            if (sb != m_stable) begin
                m_run++;
                if (m_run == DEB) begin
                    m_stable = sb;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        bl = m_bursts[CW-1:0];
        exp_q.push_back({m_clock(), m_cs, m_stalled, (m_active || m_bursts != 0), bl});
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        logic [CW+3:0] e;
        e = exp_q.pop_front();
        check("clock",        32'(bus.clock),        32'(e[CW+3]));
        check("clock_status", 32'(bus.clock_status), 32'(e[CW+2]));
        check("stalled",      32'(bus.stalled),      32'(e[CW+1]));
        check("busy",         32'(bus.busy),         32'(e[CW]));
        check("burst_left",   32'(bus.burst_left),   32'(e[CW-1:0]));
        if (bus.clock === 1'b1 && last_clock !== 1'b1) rises++;
        last_clock = bus.clock;
    endtask

    task automatic tick();
        @(posedge clk_50);
        model_edge();
        @(negedge clk_50);
        compare_all();
    endtask

    task automatic hold_button(input logic lvl, input int n);
        bus.push_manual_clock = lvl;
        repeat (n) tick();
    endtask

    task automatic wait_clock(input logic val, input int limit, input string tag);
        int n = 0;
        while (bus.clock !== val && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.clock), 32'(val));
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        reset                  = 1'b1;
        bus.mode               = 2'b00;
        bus.push_manual_clock  = 1'b1;
        bus.FLAG_input         = 1'b0;
        bus.FPGA_input_confirm = 1'b0;
        bus.halt               = 1'b0;
        rises                  = 0;
        last_clock             = 1'b0;
        model_reset();

        // Reset state, then free-run with the first rise one cycle after release.
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("first_rise", 32'(bus.clock), 32'd1);
        rises = 0;
        repeat (24) tick();
        check("run_rises", 32'(rises), 32'd3);

        // Single-step: one period per debounced press, short glitch ignored.
        bus.mode = 2'b11;
        wait_idle(20);
        bus.mode = 2'b01;
        rises = 0;
        hold_button(1'b0, 20);
        hold_button(1'b1, 20);
        check("step_rises", 32'(rises), 32'd1);
        check("step_busy", 32'(bus.busy), 32'd0);
        rises = 0;
        hold_button(1'b0, 5);
        hold_button(1'b1, 20);
        check("glitch_rises", 32'(rises), 32'd0);

        // Burst: three periods, second press lands mid-burst and is dropped.
        bus.mode = 2'b10;
        rises = 0;
        hold_button(1'b0, 12);
        hold_button(1'b1, 10);
        hold_button(1'b0, 12);
        hold_button(1'b1, 30);
        check("burst_rises", 32'(rises), 32'd3);
        check("burst_busy", 32'(bus.busy), 32'd0);

        // Halt two cycles into HIGH: period completes, then clock freezes.
        bus.mode = 2'b00;
        wait_clock(1'b1, 20, "run_rise");
        repeat (2) tick();
        bus.halt = 1'b1;
        repeat (16) tick();
        check("halt_clock", 32'(bus.clock), 32'd0);
        check("halt_status", 32'(bus.clock_status), 32'd1);
        check("halt_stalled", 32'(bus.stalled), 32'd1);
        bus.halt = 1'b0;
        wait_clock(1'b1, 2, "halt_resume");

        // Waiting for user input freezes the clock until confirmed.
        bus.FLAG_input = 1'b1;
        repeat (12) tick();
        rises = 0;
        repeat (10) tick();
        check("flag_rises", 32'(rises), 32'd0);
        bus.FPGA_input_confirm = 1'b1;
        wait_clock(1'b1, 3, "confirm_resume");
        bus.FLAG_input         = 1'b0;
        bus.FPGA_input_confirm = 1'b0;

        // Asynchronous reset in the HIGH half of a burst.
        bus.mode = 2'b11;
        wait_idle(20);
        bus.mode = 2'b10;
        hold_button(1'b0, 12);
        bus.push_manual_clock = 1'b1;
        check("pre_reset_clock", 32'(bus.clock), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("areset_clock", 32'(bus.clock), 32'd0);
        check("areset_burst_left", 32'(bus.burst_left), 32'd0);
        check("areset_busy", 32'(bus.busy), 32'd0);
        model_reset();
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();

        // Random mode/stall/button traffic checked cycle by cycle.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) bus.halt = ~bus.halt;
            if ($urandom_range(0, 9) == 0) bus.FLAG_input = ~bus.FLAG_input;
            if ($urandom_range(0, 9) == 0) bus.FPGA_input_confirm = ~bus.FPGA_input_confirm;
            if ($urandom_range(0, 9) == 0) bus.push_manual_clock = ~bus.push_manual_clock;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
